// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Holds redirect encodings, FSM state encoding and reset/exception vectors.
package pc_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OFF_W = 16;
    localparam int unsigned IDX_W = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_0080;

    typedef enum logic [1:0] {
        REDIR_BRANCH = 2'd0,
        REDIR_JUMP   = 2'd1,
        REDIR_JR     = 2'd2,
        REDIR_RSVD   = 2'd3
    } redir_kind_e;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_FETCH      = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_HOLD       = 2'd3
    } state_e;

    // One-entry redirect holding register; the target is resolved at capture.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } pend_redir_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational redirect target computation: branch, J/JAL, JR.
// A misaligned JR resolves to the exception vector and is flagged.
module pc_sequencer_next_pc_calc
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [XLEN-1:0]  pc_base_i,
    input  redir_kind_e      kind_i,
    input  logic [OFF_W-1:0] branch_off_i,
    input  logic [IDX_W-1:0] jump_index_i,
    input  logic [XLEN-1:0]  jr_target_i,
    output logic [XLEN-1:0]  target_c,
    output logic             kind_ok_c,
    output logic             misaligned_c
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_disp;

    assign seq_pc  = pc_base_i + XLEN'(4);
    assign br_disp = {{(XLEN-OFF_W-2){branch_off_i[OFF_W-1]}}, branch_off_i, 2'b00};

    always_comb begin
        target_c     = seq_pc;
        kind_ok_c    = 1'b1;
        misaligned_c = 1'b0;
        case (kind_i)
            REDIR_BRANCH: target_c = seq_pc + br_disp;
            REDIR_JUMP:   target_c = {seq_pc[XLEN-1:XLEN-4], jump_index_i, 2'b00};
            REDIR_JR: begin
                if (is_word_aligned(jr_target_i)) begin
                    target_c = jr_target_i;
                end else begin
                    target_c     = EXC_VECTOR;
                    misaligned_c = 1'b1;
                end
            end
            default: kind_ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, fetches over a req/ack handshake
// and applies branch/jump/JR redirects at safe points in the fetch cycle.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [1:0]       redir_kind,
    input  logic [OFF_W-1:0] branch_off,
    input  logic [IDX_W-1:0] jump_index,
    input  logic [XLEN-1:0]  jr_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic [XLEN-1:0]  pc,
    output logic             addr_err
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            addr_err_q, addr_err_d;
    pend_redir_t     pend_q, pend_d;

    logic [XLEN-1:0] calc_target;
    logic            calc_kind_ok;
    logic            calc_misaligned;
    logic            redir_take;
    logic            have_redir;
    logic [XLEN-1:0] redir_tgt;

    pc_sequencer_next_pc_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_calc (
        .pc_base_i    (instr_pc_q),
        .kind_i       (redir_kind_e'(redir_kind)),
        .branch_off_i (branch_off),
        .jump_index_i (jump_index),
        .jr_target_i  (jr_target),
        .target_c     (calc_target),
        .kind_ok_c    (calc_kind_ok),
        .misaligned_c (calc_misaligned)
    );

    // An incoming redirect in the same cycle overrides the stored one.
    assign redir_take = redir_valid && calc_kind_ok && (state_q != ST_RESET_HOLD);
    assign have_redir = redir_take || pend_q.valid;
    assign redir_tgt  = redir_take ? calc_target : pend_q.target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET_HOLD;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            pend_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            addr_err_q    <= addr_err_d;
            pend_q        <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pend_d     = pend_q;
        addr_err_d = 1'b0;

        if (redir_take) begin
            pend_d.valid  = 1'b1;
            pend_d.target = calc_target;
            addr_err_d    = calc_misaligned;
        end

        case (state_q)
            ST_RESET_HOLD: state_d = ST_FETCH;
            ST_FETCH: begin
                // PC only moves once the outstanding request is acknowledged.
                if (imem_ack) begin
                    if (have_redir) begin
                        pc_d   = redir_tgt;
                        pend_d = '0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                pc_d    = have_redir ? redir_tgt : pc_q + XLEN'(4);
                pend_d  = '0;
                state_d = stall ? ST_HOLD : ST_FETCH;
            end
            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase

        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_ISSUE);
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign addr_err    = addr_err_q;

endmodule
